// File: rtl/posit_add_align_norm.sv
// Posit adder core: magnitude ordering, mantissa alignment, add/sub and
// normalisation in a 3-stage valid/ready pipeline feeding the rounding stage.
module posit_add_align_norm #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [N-1:0]           IN1,
  input  logic [N-1:0]           IN2,
  input  logic                   S1,
  input  logic                   S2,
  input  logic signed [RS:0]     K1,
  input  logic signed [RS:0]     K2,
  input  logic [ES-1:0]          EX1,
  input  logic [ES-1:0]          EX2,
  input  logic [N-1:0]           M1,
  input  logic [N-1:0]           M2,
  input  logic                   inf1,
  input  logic                   inf2,
  input  logic                   zero1,
  input  logic                   zero2,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic signed [ES+RS:0]  LE_O,
  output logic [ES-1:0]          E_O,
  output logic [N:0]             Add_Mant,
  output logic [N-1:0]           Add_Mant_N,
  output logic signed [RS:0]     R_O,
  output logic                   LS,
  output logic [N-1:0]           IN1_O,
  output logic [N-1:0]           IN2_O,
  output logic                   inf1_O,
  output logic                   inf2_O,
  output logic                   zero1_O,
  output logic                   zero2_O
);

  localparam int LW = ES + RS + 1;
  localparam int RW = RS + 1;

  typedef struct packed {
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         inf1;
    logic         inf2;
    logic         zero1;
    logic         zero2;
  } pass_t;

  pass_t pt_d;
  assign pt_d = {IN1, IN2, inf1, inf2, zero1, zero2};

  logic v1_q, v2_q, v3_q;
  logic ld1, ld2, ld3;

  // A stage loads when empty or when its content moves on this edge.
  assign ld3       = ~v3_q | OUT_READY;
  assign ld2       = ~v2_q | ld3;
  assign ld1       = ~v1_q | ld2;
  assign IN_READY  = ld1;
  assign OUT_VALID = v3_q;

  // Stage 1: order operands by (LE, M)
  logic signed [LW-1:0] le1, le2;
  logic signed [LW-1:0] le_l_d, le_s;
  logic [LW-1:0]        d_d;
  logic                 op1_l;

  assign le1    = {K1, EX1};
  assign le2    = {K2, EX2};
  assign op1_l  = (le1 > le2) || ((le1 == le2) && (M1 >= M2));
  assign le_l_d = op1_l ? le1 : le2;
  assign le_s   = op1_l ? le2 : le1;
  assign d_d    = le_l_d - le_s;

  logic signed [LW-1:0] s1_le_q;
  logic [LW-1:0]        s1_d_q;
  logic [N-1:0]         s1_ml_q, s1_ms_q;
  logic                 s1_ls_q, s1_sub_q;
  pass_t                s1_pt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      s1_le_q  <= '0;
      s1_d_q   <= '0;
      s1_ml_q  <= '0;
      s1_ms_q  <= '0;
      s1_ls_q  <= 1'b0;
      s1_sub_q <= 1'b0;
      s1_pt_q  <= '0;
    end else if (ld1) begin
      v1_q <= IN_VALID;
      if (IN_VALID) begin
        s1_le_q  <= le_l_d;
        s1_d_q   <= d_d;
        s1_ml_q  <= op1_l ? M1 : M2;
        s1_ms_q  <= op1_l ? M2 : M1;
        s1_ls_q  <= op1_l ? S1 : S2;
        s1_sub_q <= S1 ^ S2;
        s1_pt_q  <= pt_d;
      end
    end
  end

  // Stage 2: align the smaller mantissa and add/subtract
  logic [N-1:0] ms_d;
  logic [N:0]   am_d;

  assign ms_d = (s1_d_q >= LW'(N)) ? '0 : (s1_ms_q >> s1_d_q);
  assign am_d = s1_sub_q ? ({1'b0, s1_ml_q} - {1'b0, ms_d})
                         : ({1'b0, s1_ml_q} + {1'b0, ms_d});

  logic signed [LW-1:0] s2_le_q;
  logic [N:0]           s2_am_q;
  logic                 s2_ls_q;
  pass_t                s2_pt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q    <= 1'b0;
      s2_le_q <= '0;
      s2_am_q <= '0;
      s2_ls_q <= 1'b0;
      s2_pt_q <= '0;
    end else if (ld2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_le_q <= s1_le_q;
        s2_am_q <= am_d;
        s2_ls_q <= s1_ls_q;
        s2_pt_q <= s1_pt_q;
      end
    end
  end

  // Stage 3: normalise and derive regime shift
  logic [RW-1:0]        lzc;
  logic [N-1:0]         amn_d;
  logic signed [LW-1:0] leo_d, k_d, mag;
  logic signed [RW-1:0] r_d;
  logic                 am_zero;

  always_comb begin
    lzc = RW'(N);
    for (int i = 0; i < N; i++) begin
      if (s2_am_q[i]) lzc = RW'(N - 1 - i);
    end
  end

  assign am_zero = (s2_am_q == '0);

  always_comb begin
    amn_d = '0;
    leo_d = '0;
    if (s2_am_q[N]) begin
      amn_d = s2_am_q[N:1];
      leo_d = s2_le_q + LW'(1);
    end else if (!am_zero) begin
      amn_d = s2_am_q[N-1:0] << lzc;
      leo_d = s2_le_q - LW'(lzc);
    end
  end

  assign k_d = leo_d >>> ES;
  assign mag = k_d[LW-1] ? -k_d : k_d + LW'(1);
  assign r_d = am_zero ? '0
             : (mag > LW'(N - 1)) ? RW'(N - 1) : mag[RS:0];

  logic signed [LW-1:0] le_o_q;
  logic [N:0]           am_q;
  logic [N-1:0]         amn_q;
  logic signed [RW-1:0] r_q;
  logic                 ls_q;
  pass_t                s3_pt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q    <= 1'b0;
      le_o_q  <= '0;
      am_q    <= '0;
      amn_q   <= '0;
      r_q     <= '0;
      ls_q    <= 1'b0;
      s3_pt_q <= '0;
    end else if (ld3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        le_o_q  <= leo_d;
        am_q    <= s2_am_q;
        amn_q   <= amn_d;
        r_q     <= r_d;
        ls_q    <= s2_ls_q;
        s3_pt_q <= s2_pt_q;
      end
    end
  end

  assign LE_O       = le_o_q;
  assign E_O        = le_o_q[ES-1:0];
  assign Add_Mant   = am_q;
  assign Add_Mant_N = amn_q;
  assign R_O        = r_q;
  assign LS         = ls_q;
  assign IN1_O      = s3_pt_q.in1;
  assign IN2_O      = s3_pt_q.in2;
  assign inf1_O     = s3_pt_q.inf1;
  assign inf2_O     = s3_pt_q.inf2;
  assign zero1_O    = s3_pt_q.zero1;
  assign zero2_O    = s3_pt_q.zero2;

endmodule

// File: tb/tb_posit_add_align_norm.sv
// Bench for posit_add_align_norm: directed cases, backpressure, reset
// flush and randomized beats against an arithmetic reference model.
module tb_posit_add_align_norm;

  logic               clk = 1'b0;
  logic               rst;
  logic               IN_VALID, IN_READY;
  logic [31:0]        IN1, IN2;
  logic               S1, S2;
  logic signed [5:0]  K1, K2;
  logic [1:0]         EX1, EX2;
  logic [31:0]        M1, M2;
  logic               inf1, inf2, zero1, zero2;
  logic               OUT_VALID, OUT_READY;
  logic signed [7:0]  LE_O;
  logic [1:0]         E_O;
  logic [32:0]        Add_Mant;
  logic [31:0]        Add_Mant_N;
  logic signed [5:0]  R_O;
  logic               LS;
  logic [31:0]        IN1_O, IN2_O;
  logic               inf1_O, inf2_O, zero1_O, zero2_O;

  posit_add_align_norm #(.N(32), .ES(2)) dut (
    .clk(clk), .rst(rst),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN1(IN1), .IN2(IN2), .S1(S1), .S2(S2),
    .K1(K1), .K2(K2), .EX1(EX1), .EX2(EX2),
    .M1(M1), .M2(M2),
    .inf1(inf1), .inf2(inf2), .zero1(zero1), .zero2(zero2),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .LE_O(LE_O), .E_O(E_O), .Add_Mant(Add_Mant),
    .Add_Mant_N(Add_Mant_N), .R_O(R_O), .LS(LS),
    .IN1_O(IN1_O), .IN2_O(IN2_O),
    .inf1_O(inf1_O), .inf2_O(inf2_O),
    .zero1_O(zero1_O), .zero2_O(zero2_O)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] in1, in2;
    bit          s1, s2;
    int          k1, k2, ex1, ex2;
    logic [31:0] m1, m2;
    logic [3:0]  fl;
  } beat_t;

  typedef struct {
    logic [7:0]  le;
    logic [1:0]  e;
    logic [32:0] am;
    logic [31:0] amn;
    logic [5:0]  r;
    bit          ls;
    logic [31:0] in1, in2;
    logic [3:0]  fl;
  } exp_t;

  exp_t  q[$];
  exp_t  mon_e;
  beat_t cur;
  int    checks = 0;
  int    errors = 0;
  bit    rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input beat_t b);
    exp_t   r;
    int     le1, le2, leL, leS, d, leo, k, rr;
    longint mL, mS, ms, sum;
    bit     op1;
    le1 = b.k1 * 4 + b.ex1;
    le2 = b.k2 * 4 + b.ex2;
    op1 = (le1 > le2) || (le1 == le2 && b.m1 >= b.m2);
    leL = op1 ? le1 : le2;
    leS = op1 ? le2 : le1;
    mL  = op1 ? longint'(b.m1) : longint'(b.m2);
    mS  = op1 ? longint'(b.m2) : longint'(b.m1);
    r.ls = op1 ? b.s1 : b.s2;
    d   = leL - leS;
    ms  = (d >= 32) ? 64'd0 : (mS >> d);
    sum = (b.s1 != b.s2) ? mL - ms : mL + ms;
    r.am = 33'(sum);
    leo = 0;
    rr  = 0;
    r.amn = '0;
    if (sum != 0) begin
      if (sum >= 64'h1_0000_0000) begin
        r.amn = 32'(sum >> 1);
        leo   = leL + 1;
      end else begin
        leo = leL;
        while (sum < 64'h8000_0000) begin
          sum = sum * 2;
          leo--;
        end
        r.amn = 32'(sum);
      end
      k  = leo >>> 2;
      rr = (k >= 0) ? k + 1 : -k;
      if (rr > 31) rr = 31;
    end
    r.le  = 8'(leo);
    r.e   = 2'(leo);
    r.r   = 6'(rr);
    r.in1 = b.in1;
    r.in2 = b.in2;
    r.fl  = b.fl;
    return r;
  endfunction

  function automatic beat_t mk(bit s1, int k1, int ex1, logic [31:0] m1,
                               bit s2, int k2, int ex2, logic [31:0] m2);
    beat_t b;
    b.s1 = s1; b.k1 = k1; b.ex1 = ex1; b.m1 = m1;
    b.s2 = s2; b.k2 = k2; b.ex2 = ex2; b.m2 = m2;
    b.in1 = $urandom; b.in2 = $urandom;
    b.fl  = 4'($urandom_range(0, 15));
    return b;
  endfunction

  function automatic beat_t gen();
    beat_t b;
    int    mode;
    b = mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)) - 20,
           int'($urandom_range(0, 3)), 32'h8000_0000 | $urandom,
           1'($urandom_range(0, 1)), int'($urandom_range(0, 40)) - 20,
           int'($urandom_range(0, 3)), 32'h8000_0000 | $urandom);
    mode = int'($urandom_range(0, 7));
    if (mode == 0) begin
      b.k2 = b.k1; b.ex2 = b.ex1; b.m2 = b.m1; b.s2 = ~b.s1;
    end else if (mode == 1) begin
      b.k2 = b.k1; b.ex2 = b.ex1;
    end else if (mode == 2) begin
      b.m2 = b.m1 ^ 32'(1 << $urandom_range(0, 8));
      b.k2 = b.k1; b.ex2 = b.ex1;
    end
    return b;
  endfunction

  task automatic drive(input beat_t b);
    cur   = b;
    IN1   = b.in1;  IN2 = b.in2;
    S1    = b.s1;   S2  = b.s2;
    K1    = 6'(b.k1); K2 = 6'(b.k2);
    EX1   = 2'(b.ex1); EX2 = 2'(b.ex2);
    M1    = b.m1;   M2  = b.m2;
    inf1  = b.fl[3]; inf2 = b.fl[2];
    zero1 = b.fl[1]; zero2 = b.fl[0];
  endtask

  task automatic send(input beat_t b);
    int t;
    bit acc;
    t = 0;
    drive(b);
    IN_VALID = 1'b1;
    do begin
      @(negedge clk);
      acc = IN_READY;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    IN_VALID = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      OUT_READY = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (OUT_VALID && OUT_READY) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'(OUT_VALID), 64'd0);
        end else begin
          mon_e = q.pop_front();
          chk("le",    {56'd0, LE_O[7:0]}, {56'd0, mon_e.le});
          chk("e",     64'(E_O), 64'(mon_e.e));
          chk("am",    64'(Add_Mant), 64'(mon_e.am));
          chk("amn",   64'(Add_Mant_N), 64'(mon_e.amn));
          chk("r",     {58'd0, R_O[5:0]}, {58'd0, mon_e.r});
          chk("ls",    64'(LS), 64'(mon_e.ls));
          chk("in1",   64'(IN1_O), 64'(mon_e.in1));
          chk("in2",   64'(IN2_O), 64'(mon_e.in2));
          chk("flags", 64'({inf1_O, inf2_O, zero1_O, zero2_O}),
              64'(mon_e.fl));
        end
      end
      if (IN_VALID && IN_READY) q.push_back(model(cur));
    end
  end

  beat_t       bp[4];
  logic [31:0] held;

  initial begin
    rst = 1'b1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    drive(mk(0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ovalid", 64'(OUT_VALID), 64'd0);
    chk("rst_iready", 64'(IN_READY), 64'd1);
    chk("rst_am", 64'(Add_Mant), 64'd0);
    chk("rst_le", {56'd0, LE_O[7:0]}, 64'd0);
    @(posedge clk);
    #1;

    // 1.0 + 1.0 with explicit latency check
    send(mk(0, 0, 0, 32'h8000_0000, 0, 0, 0, 32'h8000_0000));
    @(posedge clk); #1;
    chk("lat_early", 64'(OUT_VALID), 64'd0);
    @(posedge clk); #1;
    chk("lat_ovalid", 64'(OUT_VALID), 64'd1);
    chk("t1_am", 64'(Add_Mant), 64'h1_0000_0000);
    chk("t1_amn", 64'(Add_Mant_N), 64'h8000_0000);
    chk("t1_le", {56'd0, LE_O[7:0]}, 64'h01);
    chk("t1_e", 64'(E_O), 64'd1);
    chk("t1_r", {58'd0, R_O[5:0]}, 64'd1);
    chk("t1_ls", 64'(LS), 64'd0);

    // 1.5 + -1.0
    send(mk(0, 0, 0, 32'hC000_0000, 1, 0, 0, 32'h8000_0000));
    repeat (2) @(posedge clk); #1;
    chk("t2_am", 64'(Add_Mant), 64'h0_4000_0000);
    chk("t2_le", {56'd0, LE_O[7:0]}, 64'hFF);
    chk("t2_e", 64'(E_O), 64'd3);
    chk("t2_r", {58'd0, R_O[5:0]}, 64'd1);

    // -1.0 + 2^-40 : alignment beyond width
    send(mk(1, 0, 0, 32'h8000_0000, 0, -10, 0, 32'h8000_0000));
    repeat (2) @(posedge clk); #1;
    chk("t3_amn", 64'(Add_Mant_N), 64'h8000_0000);
    chk("t3_le", {56'd0, LE_O[7:0]}, 64'd0);
    chk("t3_ls", 64'(LS), 64'd1);

    // x + (-x)
    send(mk(0, 3, 2, 32'hA5A5_0000, 1, 3, 2, 32'hA5A5_0000));
    repeat (2) @(posedge clk); #1;
    chk("t4_ovalid", 64'(OUT_VALID), 64'd1);
    chk("t4_am", 64'(Add_Mant), 64'd0);
    chk("t4_r", {58'd0, R_O[5:0]}, 64'd0);
    repeat (3) @(posedge clk); #1;

    // Backpressure
    for (int i = 0; i < 4; i++) bp[i] = gen();
    OUT_READY = 1'b0;
    send(bp[0]);
    send(bp[1]);
    send(bp[2]);
    chk("bp_iready", 64'(IN_READY), 64'd0);
    fork
      send(bp[3]);
      begin
        @(negedge clk);
        held = Add_Mant_N;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_hold_v", 64'(OUT_VALID), 64'd1);
        chk("bp_hold_d", 64'(Add_Mant_N), 64'(held));
        chk("bp_iready2", 64'(IN_READY), 64'd0);
        chk("bp_qsize", 64'(q.size()), 64'd3);
        @(posedge clk); #1;
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("bp_stream", 64'(OUT_VALID), 64'd1);
        end
      end
    join
    repeat (3) @(posedge clk); #1;
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Reset with two beats in flight
    send(gen());
    send(gen());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ovalid", 64'(OUT_VALID), 64'd0);
    chk("mid_rst_iready", 64'(IN_READY), 64'd1);
    chk("mid_rst_amn", 64'(Add_Mant_N), 64'd0);
    chk("mid_rst_in1", 64'(IN1_O), 64'd0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_stale", 64'(OUT_VALID), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(gen());
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    OUT_READY = 1'b1;
    for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
    #1;
    chk("final_drain", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/posit_add_align_norm.md
Name: posit_add_align_norm

Overview:
- Pipelined arithmetic core of the posit adder: sits directly upstream of the rounding/packing stage.
- Takes decoded fields of two posit operands, then:
  - orders them by magnitude,
  - aligns mantissas,
  - adds or subtracts,
  - normalises the result.
- Produces the sign, scaled exponent, exponent field, regime shift amount and normalised mantissa the rounding stage consumes.
- 3-stage pipeline with valid/ready handshake on both sides; operand words and special flags travel alongside the data.

Parameters:
- N, 32, posit word width
- ES, 2, exponent field width
- RS, $clog2(N), regime count width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- IN_VALID  in  1  input beat valid
- IN_READY  out  1  stage 1 can accept a beat
- IN1, IN2  in  N  raw posit words (passed through)
- S1, S2  in  1  operand signs
- K1, K2  in  RS+1  signed regime value k
- EX1, EX2  in  ES  exponent fields
- M1, M2  in  N  mantissas, hidden bit at [N-1] (=1 for non-special operands)
- inf1, inf2, zero1, zero2  in  1  special flags (passed through)
- OUT_VALID  out  1  output beat valid
- OUT_READY  in  1  downstream accepts
- LE_O  out  ES+RS+1  signed scaled result exponent
- E_O  out  ES  LE_O[ES-1:0]
- Add_Mant  out  N+1  raw sum before normalisation
- Add_Mant_N  out  N  normalised mantissa, leading 1 at [N-1]
- R_O  out  RS+1  signed regime shift amount
- LS  out  1  result sign
- IN1_O, IN2_O, inf1_O, inf2_O, zero1_O, zero2_O  out  pass-through copies

Behaviour:
- Reset:
  - all three stage-valid bits clear, so OUT_VALID=0 and IN_READY=1 in the cycle after reset.
  - All data registers clear to 0.
  - A reset mid-operation discards in-flight beats.
- Handshake:
  - A beat transfers when VALID&READY are high on a clock edge.
  - Stage i loads when stage i is empty or advancing.
  - IN_READY = ~v1 | advance1 (combinational from OUT_READY through the chain).
  - Outputs are registered and held stable while OUT_VALID & ~OUT_READY.
  - Latency is 3 cycles with no stall; throughput is 1 beat/cycle.
  - Order is preserved.
- Stage 1, order:
  - LEx = {Kx, EXx} as signed (Kx·2^ES + EXx).
  - L = operand with larger (LE, M); on a full tie L = operand 1.
  - LS = S_L.
  - SUB = S1^S2.
  - D = LE_L - LE_S, unsigned, ES+RS+1 bits.
- Stage 2, align and add:
  - Ms = M_S >> D; if D ≥ N, Ms = 0.
  - Add_Mant = SUB ? {0,M_L} - {0,Ms} : {0,M_L} + {0,Ms}. Width N+1, never negative.
- Stage 3, normalise:
  - If Add_Mant[N]=1: Add_Mant_N = Add_Mant[N:1] and LE_O = LE_L + 1.
  - Else: Add_Mant_N = Add_Mant[N-1:0] << lzc, where lzc = leading zeros of Add_Mant[N-1:0] (0..N); LE_O = LE_L - lzc.
  - If Add_Mant = 0: Add_Mant_N = 0, LE_O = 0, R_O = 0.
  - k = LE_O >>> ES.
  - R_O = k+1 when k ≥ 0, -k when k < 0; saturate to N-1.
  - E_O = LE_O[ES-1:0] (two's complement, so LE_O = -1 gives E_O = 2^ES-1).
- Special flags and IN1/IN2 pass through unmodified. Arithmetic fields for special operands are don't-care, but must be deterministic with no X.
- LE_O is ES+RS+1 bits; overflow at the LE_O extremes wraps and is not checked (R_O saturation covers representable range).

Test Plan:
- N=32, ES=2.
  - 1.0+1.0 (K=0, EX=0, M=0x80000000, both signs 0) -> after 3 cycles: Add_Mant=0x1_00000000, Add_Mant_N=0x80000000, LE_O=1, E_O=1, R_O=1, LS=0.
  - 1.5 + (-1.0) (M1=0xC0000000, M2=0x80000000, S2=1) -> Add_Mant=0x040000000, Add_Mant_N=0x80000000, LE_O=-1, E_O=3, R_O=1, LS=0.
  - -1.0 + 2^-40 (K2=-10, EX2=0) -> D=40 ≥ N, so Ms=0; Add_Mant_N=0x80000000, LE_O=0, R_O=1, LS=1.
  - x + (-x) (equal fields, opposite signs) -> Add_Mant=0, Add_Mant_N=0, LE_O=0, R_O=0, OUT_VALID=1.
  - Backpressure: OUT_READY=0, drive 4 back-to-back beats -> 3 held, IN_READY=0 from the 4th cycle, no beat lost or duplicated. OUT_READY=1 -> 4 results in input order on consecutive cycles.
  - rst asserted for one cycle with 2 beats in flight -> next cycle OUT_VALID=0, IN_READY=1, all outputs 0; no stale beat appears later.
